// File: rtl/data_mem_bus_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_bus_ctrl_pkg
//   Shared types and constants for the core-to-dataMem bus controller.
//   - bus_state_e        : controller FSM states (IDLE / ACCESS / RESP)
//   - MEM_WAIT_STATES    : default number of memory-side wait-state cycles
//   - CNT_WIDTH          : width of the wait-state counter
//   - clamp_wait_states(): maps an out-of-range WAIT_STATES onto 1
// ----------------------------------------------------------------------------
package data_mem_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_ACCESS = 2'd1,
    BUS_RESP   = 2'd2
  } bus_state_e;

  localparam int unsigned MEM_WAIT_STATES = 1;
  localparam int unsigned CNT_WIDTH       = 4;
  localparam int unsigned MAX_WAIT_STATES = (1 << CNT_WIDTH) - 1;

  // The counter cannot represent 0 or anything above 15 wait states; such a
  // setting falls back to the single-cycle access.
  function automatic int unsigned clamp_wait_states(input int unsigned ws);
    if (ws < 1 || ws > MAX_WAIT_STATES) begin
      return 1;
    end
    return ws;
  endfunction

endpackage

// File: rtl/data_mem_bus_ctrl.sv
// ----------------------------------------------------------------------------
// data_mem_bus_ctrl
//   Bridges the core data port (req/gnt/rvalid) to dataMem. Each accepted
//   request is registered, presented to dataMem for WAIT_STATES cycles, then
//   answered with a one-cycle rvalid_o pulse. Reads and writes take the same
//   path, so responses are uniform and strictly in order, one at a time.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req_i / gnt_o   core request / same-cycle accept (gnt_o is combinational)
//   rvalid_o        one-cycle response strobe, rdata_o valid while high
//   we_i, addr_i,
//   wdata_i, be_i   access attributes, sampled on the granting edge
//   rdata_o         registered read data (0 for writes)
//   mem_we_o, mem_addr_o, mem_wdata_o, mem_transfer_o
//                   dataMem write enable / address / data_in / byte mask
//   mem_rdata_i     dataMem data_out (combinational read path expected)
// ----------------------------------------------------------------------------
module data_mem_bus_ctrl
  import data_mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TRANSFER_WIDTH = 4,
  parameter int unsigned WAIT_STATES    = MEM_WAIT_STATES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // core side
  input  logic                      req_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  input  logic                      we_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [TRANSFER_WIDTH-1:0] be_i,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  // dataMem side
  output logic                      mem_we_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [TRANSFER_WIDTH-1:0] mem_transfer_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam logic [CNT_WIDTH-1:0] WS_LOAD = CNT_WIDTH'(clamp_wait_states(WAIT_STATES));

  bus_state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      we_q, we_d;          // captured direction of the access
  logic                      mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [TRANSFER_WIDTH-1:0] be_q, be_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      gnt;
  logic                      capture;

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    mem_we_d = 1'b0;      // write strobe lasts only the first ACCESS cycle
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    gnt      = 1'b0;
    capture  = 1'b0;

    unique case (state_q)
      BUS_IDLE: begin
        gnt     = req_i;
        capture = req_i;
      end

      BUS_ACCESS: begin
        cnt_d = cnt_q - 1'b1;
        // <= 1 rather than == 1 so a corrupted zero count cannot wrap to 15.
        if (cnt_q <= 1) begin
          state_d = BUS_RESP;
          cnt_d   = '0;
          rdata_d = we_q ? '0 : mem_rdata_i;
        end
      end

      BUS_RESP: begin
        gnt     = req_i;
        capture = req_i;
        if (!req_i) begin
          state_d = BUS_IDLE;
        end
      end

      default: begin
        state_d = BUS_IDLE;
      end
    endcase

    // Accept a request (from IDLE or back-to-back from RESP).
    if (capture) begin
      state_d  = BUS_ACCESS;
      cnt_d    = WS_LOAD;
      we_d     = we_i;
      addr_d   = addr_i;
      wdata_d  = wdata_i;
      be_d     = be_i;
      // An all-zero byte mask still completes but never strobes the memory.
      mem_we_d = we_i & (|be_i);
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BUS_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      mem_we_q <= mem_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign gnt_o          = gnt;
  assign rvalid_o       = (state_q == BUS_RESP);
  assign rdata_o        = rdata_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign mem_transfer_o = be_q;

endmodule
